// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch slice.
package fetch_pkg;

   localparam int IMEM_AW = 13;
   localparam int XLEN    = 32;

   localparam logic [IMEM_AW-1:0] PC_STEP = 13'd4;

   typedef struct packed {
      logic [IMEM_AW-1:0] pc;
      logic [XLEN-1:0]    instr;
   } fetch_entry_t;

   // Redirect targets are word addresses; the low byte-offset bits are dropped.
   function automatic logic [IMEM_AW-1:0] word_align(input logic [IMEM_AW-1:0] pc);
      return {pc[IMEM_AW-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of {pc, instr} entries with synchronous flush and async reset.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         flush,
   input  logic         push,
   input  logic         pop,
   input  fetch_entry_t wdata,
   output fetch_entry_t rdata,
   output logic         full,
   output logic         empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH) + 1;

   fetch_entry_t        mem [DEPTH];
   fetch_entry_t        hold;
   fetch_entry_t        head;
   logic [AW-1:0]       rd_ptr;
   logic [AW-1:0]       wr_ptr;
   logic [CW-1:0]       count;
   logic                pop_ok;
   logic                push_ok;

   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign pop_ok  = pop & ~empty;
   assign push_ok = push & (~full | pop_ok);

   // When empty the head shows the last value seen, so decode never sees stale storage.
   assign head  = empty ? hold : mem[rd_ptr];
   assign rdata = head;

   always_ff @(posedge clk) begin
      if (push_ok && !flush)
         mem[wr_ptr] <= wdata;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         hold   <= '0;
      end else begin
         hold <= head;
         if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
         end else begin
            if (push_ok)
               wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)
               rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop_ok})
               2'b10:   count <= count + CW'(1);
               2'b01:   count <= count - CW'(1);
               default: count <= count;
            endcase
         end
      end
   end

endmodule

// File: rtl/inst_fetch_unit.sv
// Fetch PC, imem request and prefetch buffering toward decode.
// Optional INST_FETCH_PERF_EN adds push and redirect counters.
module inst_fetch_unit
   import fetch_pkg::*;
#(
   parameter int                 DEPTH    = 4,
   parameter logic [IMEM_AW-1:0] RESET_PC = 13'h0000
) (
   input  logic               clk_i,
   input  logic               rst_i,
   output logic [IMEM_AW-1:0] imem_addr_o,
   input  logic [XLEN-1:0]    imem_data_i,
   input  logic               redirect_i,
   input  logic [IMEM_AW-1:0] redirect_pc_i,
   output logic               instr_valid_o,
   input  logic               instr_ready_i,
   output logic [XLEN-1:0]    instr_o,
   output logic [IMEM_AW-1:0] instr_pc_o
`ifdef INST_FETCH_PERF_EN
   ,
   output logic [31:0]        fetch_cnt_o,
   output logic [31:0]        redirect_cnt_o
`endif
);

   logic [IMEM_AW-1:0] fetch_pc;
   logic               push;
   logic               pop;
   logic               full;
   logic               empty;
   fetch_entry_t       wr_entry;
   fetch_entry_t       head;

   assign imem_addr_o   = fetch_pc;
   assign instr_valid_o = ~empty;
   assign instr_o       = head.instr;
   assign instr_pc_o    = head.pc;

   assign pop  = instr_valid_o & instr_ready_i;
   // A full buffer can still take a word when decode frees a slot this cycle.
   assign push = ~redirect_i & (~full | pop);

   assign wr_entry.pc    = fetch_pc;
   assign wr_entry.instr = imem_data_i;

   fetch_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk_i),
      .rst   (rst_i),
      .flush (redirect_i),
      .push  (push),
      .pop   (pop),
      .wdata (wr_entry),
      .rdata (head),
      .full  (full),
      .empty (empty)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)
         fetch_pc <= RESET_PC;
      else if (redirect_i)
         fetch_pc <= word_align(redirect_pc_i);
      else if (push)
         fetch_pc <= fetch_pc + PC_STEP;
   end

`ifdef INST_FETCH_PERF_EN
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         fetch_cnt_o    <= '0;
         redirect_cnt_o <= '0;
      end else begin
         if (push)
            fetch_cnt_o <= fetch_cnt_o + 32'd1;
         if (redirect_i)
            redirect_cnt_o <= redirect_cnt_o + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit; imem word at byte address a is A000_0000 + a/4.
module tb_inst_fetch_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [12:0] imem_addr;
   logic [31:0] imem_data;
   logic        redirect = 1'b0;
   logic [12:0] redirect_pc = 13'h0;
   logic        instr_valid;
   logic        instr_ready = 1'b0;
   logic [31:0] instr;
   logic [12:0] instr_pc;
`ifdef INST_FETCH_PERF_EN
   logic [31:0] fetch_cnt;
   logic [31:0] redirect_cnt;
`endif

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   assign imem_data = 32'hA000_0000 + {21'b0, imem_addr[12:2]};

   inst_fetch_unit #(
      .DEPTH    (4),
      .RESET_PC (13'h0000)
   ) dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .imem_addr_o   (imem_addr),
      .imem_data_i   (imem_data),
      .redirect_i    (redirect),
      .redirect_pc_i (redirect_pc),
      .instr_valid_o (instr_valid),
      .instr_ready_i (instr_ready),
      .instr_o       (instr),
      .instr_pc_o    (instr_pc)
`ifdef INST_FETCH_PERF_EN
      ,
      .fetch_cnt_o    (fetch_cnt),
      .redirect_cnt_o (redirect_cnt)
`endif
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_head(input string tag, input logic [12:0] pc);
      check({tag, "_valid"}, {31'b0, instr_valid}, 32'd1);
      check({tag, "_pc"}, {19'b0, instr_pc}, {19'b0, pc});
      check({tag, "_instr"}, instr, 32'hA000_0000 + {21'b0, pc[12:2]});
   endtask

   initial begin
      // Reset state and first fetch
      step();
      step();
      rst = 1'b0;
      check("rst_valid", {31'b0, instr_valid}, 32'd0);
      check("rst_instr", instr, 32'h0);
      check("rst_pc", {19'b0, instr_pc}, 32'h0);
      check("rst_addr", {19'b0, imem_addr}, 32'h0);
      step();
      check_head("first", 13'h000);
      instr_ready = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         step();
         check_head("stream", 13'(4 * k));
         check("stream_addr", {19'b0, imem_addr}, 32'(4 * (k + 1)));
      end

      // Stall: exactly four pushes, then drain and sustained full-rate flow
      rst = 1'b1;
      instr_ready = 1'b0;
      #1;
      rst = 1'b0;
      for (int k = 0; k < 10; k++) step();
      check("stall_addr", {19'b0, imem_addr}, 32'h010);
      check_head("stall_head", 13'h000);
      instr_ready = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         step();
         check_head("drain", 13'(4 * k));
         check("full_depth", {19'b0, imem_addr - instr_pc}, 32'd16);
      end

      // Redirect with three buffered entries
      rst = 1'b1;
      instr_ready = 1'b0;
      #1;
      rst = 1'b0;
      step();
      step();
      step();
      check("pre_redir_addr", {19'b0, imem_addr}, 32'h00C);
      redirect = 1'b1;
      redirect_pc = 13'h0A6;
      step();
      redirect = 1'b0;
      check("redir_valid", {31'b0, instr_valid}, 32'd0);
      check("redir_addr", {19'b0, imem_addr}, 32'h0A4);
      check("redir_hold_pc", {19'b0, instr_pc}, 32'h000);
      step();
      check_head("redir_first", 13'h0A4);

      // Redirect near the top of the address space wraps to zero
      instr_ready = 1'b1;
      redirect = 1'b1;
      redirect_pc = 13'h1FF8;
      step();
      redirect = 1'b0;
      check("wrap_flush_valid", {31'b0, instr_valid}, 32'd0);
      step();
      check_head("wrap0", 13'h1FF8);
      step();
      check_head("wrap1", 13'h1FFC);
      step();
      check_head("wrap2", 13'h0000);
      step();
      check_head("wrap3", 13'h0004);

      // Async reset with two entries buffered
      instr_ready = 1'b0;
      step();
      check("two_buf_addr", {19'b0, imem_addr - instr_pc}, 32'd8);
      rst = 1'b1;
      #1;
      check("async_valid", {31'b0, instr_valid}, 32'd0);
      check("async_pc", {19'b0, instr_pc}, 32'h0);
      check("async_instr", instr, 32'h0);
      check("async_addr", {19'b0, imem_addr}, 32'h0);
`ifdef INST_FETCH_PERF_EN
      check("async_fetch_cnt", fetch_cnt, 32'd0);
      check("async_redir_cnt", redirect_cnt, 32'd0);
`endif
      @(negedge clk);
      rst = 1'b0;
      step();
      check_head("restart0", 13'h000);
      instr_ready = 1'b1;
      step();
      check_head("restart1", 13'h004);
`ifdef INST_FETCH_PERF_EN
      check("perf_fetch_cnt", fetch_cnt, 32'd2);
      check("perf_redir_cnt", redirect_cnt, 32'd0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
Requester side of the instruction-memory read interface. Holds the fetch PC, drives the 13-bit byte address to instruction memory and captures the 32-bit word returned combinationally in the same cycle. Buffers {pc, instr} pairs in a small prefetch FIFO and hands them to decode over a valid/ready handshake. Sits between instruction memory and the decode stage, and accepts redirects from branch resolution.

Parameters:
DEPTH, 4, prefetch FIFO entries; power of two, ≥2.
RESET_PC, 13'h0000, fetch PC loaded on reset; bits [1:0] must be 0.

Ports:
clk_i  input  1  clock, rising edge.
rst_i  input  1  asynchronous reset, active-high.
imem_addr_o  output  13  byte address to instruction memory; always equals fetch_pc.
imem_data_i  input  32  instruction word for imem_addr_o, valid in the same cycle.
redirect_i  input  1  flush the FIFO and restart fetch at redirect_pc_i.
redirect_pc_i  input  13  redirect target; bits [1:0] ignored and treated as 0.
instr_valid_o  output  1  the FIFO head is valid.
instr_ready_i  input  1  decode accepts the head.
instr_o  output  32  instruction at the FIFO head.
instr_pc_o  output  13  byte PC of instr_o.

Behaviour:
- Reset (asynchronous): fetch_pc=RESET_PC, FIFO empty (count=0, rd_ptr=wr_ptr=0), instr_valid_o=0, instr_o=32'h0, instr_pc_o=13'h0. imem_addr_o=RESET_PC. Asserting reset mid-operation discards all buffered entries immediately.
- pop = instr_valid_o & instr_ready_i.
- push = !redirect_i & (count<DEPTH | pop).
  - When full, push and pop in the same cycle is allowed, and count stays at DEPTH.
- On push: write {fetch_pc, imem_data_i} at wr_ptr, then fetch_pc <= fetch_pc + 4.
  - Addition is modulo 2^13, so 13'h1FFC wraps to 13'h0000 with no error.
- On redirect_i, which has priority over push and pop:
  - count<=0 and pointers reset.
  - fetch_pc <= {redirect_pc_i[12:2], 2'b00}.
  - No push occurs that cycle.
  - A pop in the same cycle is not counted; decode must treat an instruction in a redirect cycle as squashed.
- Latency:
  - After reset release, or in the cycle after a redirect, the first push occurs in that cycle, and instr_valid_o=1 from the next cycle.
  - Redirect to valid is therefore 2 cycles.
- Output path: instr_o and instr_pc_o come from the FIFO head (registered storage, no combinational path from imem_data_i). While instr_valid_o=0 they hold their last values, or 0 after reset.
- Count: count_next = count + push − pop, always within 0..DEPTH.
  - instr_valid_o = (count != 0).
  - Full means count==DEPTH.
- Pointers are log2(DEPTH) bits and wrap naturally.
- Steady state with ready held high: one instruction per cycle, sequential PCs.
- Stall: with ready low, the FIFO fills after DEPTH pushes. fetch_pc then holds, and imem_addr_o is stable at the next unfetched address.

Optional Feature:
INST_FETCH_PERF_EN
- Defined: adds two outputs, each 32-bit and wrapping at 2^32:
  - fetch_cnt_o: number of pushes.
  - redirect_cnt_o: number of cycles with redirect_i high.
  - Both reset to 0 asynchronously.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- fetch_pkg:
  - IMEM_AW=13, XLEN=32.
  - typedef fetch_entry_t packed struct {logic [12:0] pc; logic [31:0] instr;}.
  - PC_STEP=13'd4.
- Sub-module fetch_fifo holds the storage, pointers, count, full/empty and flush (sync clear, async reset), parameterised by DEPTH, with fetch_entry_t as payload.
- inst_fetch_unit owns fetch_pc, the push/pop/redirect arbitration and the optional counters.

Test Plan:
- Reset, then ready=1 with imem modelled as word(i)=32'hA000_0000+i → outputs PCs 0x000, 0x004, 0x008… with instrs A0000000, A0000001…; first valid in the 2nd cycle after reset release.
- Ready=0 for 10 cycles from reset → exactly DEPTH=4 pushes; imem_addr_o holds at 0x010; then ready=1 → PCs 0x000..0x00C drain with no gap, followed by 0x010.
- Redirect to 0x0A6 while FIFO holds 3 entries → next cycle count=0, valid=0, imem_addr_o=0x0A4; the cycle after, instr_pc_o=0x0A4.
- Full FIFO, ready=1 → push and pop every cycle, count stays 4, no lost or duplicated PC.
- Redirect to 0x1FF8 with ready=1 → PCs 0x1FF8, 0x1FFC, 0x0000, 0x0004.
- Reset asserted asynchronously mid-stream with 2 entries buffered → valid drops without a clock edge; after release the sequence restarts at RESET_PC. With INST_FETCH_PERF_EN defined, both counters read 0.
